multi_timestamp: RTL
====================

MULTI_TIMESTAMP -- requirements
Module: multi_timestamp

Interface
REQ-001 Parameters SHALL be: N_CH, default 4, number of input channels (1..32); TS_WIDTH, fixed 64, external timestamp width; EVT_DEPTH, default 16, event FIFO depth (power of 2); IDENTIFIER, default 4'b0111, data-word tag.
REQ-002 Ports SHALL be:
- BUS_CLK  in  1  sole clock.
- BUS_RST  in  1  reset; synchronous, active-high.
- DI  in  N_CH  asynchronous hit inputs.
- EN_RISE  in  N_CH  per-channel enable for rising-edge capture.
- EN_FALL  in  N_CH  per-channel enable for falling-edge capture.
- EXT_TIMESTAMP  in  64  free-running timestamp, BUS_CLK domain.
- FIFO_READ  in  1  pops the current output word.
- FIFO_EMPTY  out  1  high when no output word is valid.
- FIFO_DATA  out  32  current output word, first-word-fall-through.
- LOST_CNT  out  8  saturating count of dropped events.

Function
REQ-003 Each DI bit SHALL pass through a 2-flop synchroniser, then a previous-value flop for edge detection.
REQ-004 An edge SHALL be one whose enable bit is high at the detection cycle; rising -> EDGE=1, falling -> EDGE=0.
REQ-005 On a detected edge, the channel SHALL latch EXT_TIMESTAMP and EDGE into a 1-deep hold register and set PENDING.
- Latched value = the EXT_TIMESTAMP present at clock edge e+2, where e is the first clock edge sampling the new DI level.
REQ-006 An edge detected while PENDING=1 SHALL be dropped: hold register unchanged, LOST_CNT += 1, saturating at 255.
REQ-007 If a pending event leaves on the same cycle a new edge is detected, the new edge SHALL be latched and not counted as lost.
REQ-008 A round-robin arbiter SHALL move at most one pending event per cycle into the event FIFO.
- Grant pointer starts after the last granted channel; after reset, channel 0 has highest priority.
REQ-009 Event FIFO full SHALL block grants; events stay PENDING and are not lost.
REQ-010 Event payload (72 bit) SHALL be {2'b00, EDGE, CH[4:0], TS[63:0]}.
REQ-011 Each event SHALL be emitted as three words: [31:28]=IDENTIFIER, [27:26]=word index k, [25:24]=2'b00, [23:0]=payload slice.
- k=0: payload[71:48]; k=1: payload[47:24]; k=2: payload[23:0].
REQ-012 The serializer FSM SHALL have states IDLE, W0, W1, W2.
- IDLE->W0 when the event FIFO is non-empty.
- Wk->Wk+1 on FIFO_READ.
- W2 on FIFO_READ: pops the event; goes to W0 if another event is queued, else IDLE.
REQ-013 FIFO_EMPTY SHALL be low exactly in states W0..W2; FIFO_DATA SHALL be stable until FIFO_READ.
REQ-014 FIFO_READ while FIFO_EMPTY=1 SHALL be ignored.
REQ-015 Idle-block latency SHALL be: FIFO_EMPTY falls at clock edge e+4.
REQ-016 Clearing an enable while PENDING=1 SHALL NOT cancel that pending event.

Reset
REQ-017 On BUS_RST, the following SHALL be cleared at the next clock edge:
- synchronisers, hold registers, PENDING, event FIFO, serializer (IDLE), arbiter pointer, LOST_CNT.
- Resulting outputs: FIFO_EMPTY=1, FIFO_DATA=0, LOST_CNT=0.
REQ-018 Reset mid-event SHALL discard remaining words of that event; no partial word is emitted afterwards.
REQ-019 Synchroniser flops SHALL reset to 0, so a DI held high through reset yields one rising edge after release if enabled.

Structure
REQ-020 Package multi_ts_pkg SHALL hold word-field positions, the payload width (72), the word-index codes and the FSM state encoding.
REQ-021 Per-channel sync/edge/hold/lost-request logic SHALL be sub-module ts_channel_capture, instantiated N_CH times; arbiter, event FIFO and serializer reside in multi_timestamp.

Verification
REQ-022 Single hit: N_CH=4, EN_RISE=4'b0100, EXT_TIMESTAMP counting from 0, DI[2] rises at e=100 -> three words with payload = {2'b00, 1, 5'd2, 64'd102}; word2[23:0]=24'd102.
REQ-023 Simultaneous: DI[0] and DI[3] rise together, both rise-enabled -> channel 0 event emitted first, then channel 3, with identical TS.
REQ-024 Loss: channel 1 has two rising edges 4 cycles apart while FIFO_READ is held low and the event FIFO is full -> second edge dropped, LOST_CNT=1, first event emitted intact after reads resume.
REQ-025 Both-edge mode: EN_RISE=EN_FALL=1 on channel 0, 10-cycle pulse -> two events, EDGE 1 then 0, TS difference 10.
REQ-026 Reset after W1 has been read -> FIFO_EMPTY=1 next cycle, word k=2 never appears, LOST_CNT=0.
REQ-027 Back-pressure: 20 events with EVT_DEPTH=16 and no reads -> no loss (one pending per channel); all 60 words read out in order with correct k sequence.

Source files
------------

// File: rtl/multi_ts_pkg.sv
// Shared definitions for the multi-channel timestamp block: output word layout,
// event payload geometry, word-index codes and serializer state encoding.
package multi_ts_pkg;

    localparam int TS_W      = 64;
    localparam int CH_W      = 5;
    localparam int PAYLOAD_W = 72;
    localparam int WORD_W    = 32;
    localparam int SLICE_W   = 24;

    localparam int ID_MSB  = 31;
    localparam int ID_LSB  = 28;
    localparam int K_MSB   = 27;
    localparam int K_LSB   = 26;
    localparam int RSV_MSB = 25;
    localparam int RSV_LSB = 24;

    localparam logic [1:0] WORD_K0 = 2'd0;
    localparam logic [1:0] WORD_K1 = 2'd1;
    localparam logic [1:0] WORD_K2 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } ser_state_e;

    function automatic logic [1:0] state_word_idx(input ser_state_e st);
        logic [1:0] k;
        case (st)
            ST_W0:   k = WORD_K0;
            ST_W1:   k = WORD_K1;
            ST_W2:   k = WORD_K2;
            default: k = WORD_K0;
        endcase
        return k;
    endfunction

    // Word k carries the k-th 24-bit slice of the payload, most significant first.
    function automatic logic [WORD_W-1:0] pack_word(input logic [3:0]           id,
                                                    input logic [1:0]           k,
                                                    input logic [PAYLOAD_W-1:0] payload);
        logic [WORD_W-1:0] word;
        word                  = {WORD_W{1'b0}};
        word[ID_MSB:ID_LSB]   = id;
        word[K_MSB:K_LSB]     = k;
        word[RSV_MSB:RSV_LSB] = 2'b00;
        case (k)
            WORD_K0: word[SLICE_W-1:0] = payload[2*SLICE_W +: SLICE_W];
            WORD_K1: word[SLICE_W-1:0] = payload[SLICE_W +: SLICE_W];
            WORD_K2: word[SLICE_W-1:0] = payload[0 +: SLICE_W];
            default: word[SLICE_W-1:0] = {SLICE_W{1'b0}};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/ts_channel_capture.sv
// One input channel: synchroniser, edge detector and a single-entry hold register
// that keeps one timestamped event until the arbiter takes it.
module ts_channel_capture
    import multi_ts_pkg::*;
#(
    parameter int TS_WIDTH = TS_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                di_i,
    input  logic                en_rise_i,
    input  logic                en_fall_i,
    input  logic [TS_WIDTH-1:0] ts_i,
    input  logic                grant_i,
    output logic                pending_o,
    output logic                edge_o,
    output logic [TS_WIDTH-1:0] ts_o,
    output logic                lost_o
);

    logic                sync1_q;
    logic                sync2_q;
    logic                prev_q;
    logic                pending_q;
    logic                pending_d;
    logic                edge_q;
    logic                edge_d;
    logic [TS_WIDTH-1:0] ts_q;
    logic [TS_WIDTH-1:0] ts_d;
    logic                rise_s;
    logic                fall_s;
    logic                lost_s;

    // Edge detection and hold-register update; a grant in the same cycle frees the slot.
    always_comb begin
        pending_d = pending_q;
        edge_d    = edge_q;
        ts_d      = ts_q;
        lost_s    = 1'b0;
        rise_s    = sync2_q & ~prev_q & en_rise_i;
        fall_s    = ~sync2_q & prev_q & en_fall_i;
        if (rise_s || fall_s) begin
            if (pending_q && !grant_i) begin
                lost_s = 1'b1;
            end else begin
                pending_d = 1'b1;
                edge_d    = rise_s;
                ts_d      = ts_i;
            end
        end else if (grant_i) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Synchroniser, previous-value and hold-register state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
            edge_q    <= 1'b0;
            ts_q      <= {TS_WIDTH{1'b0}};
        end else begin
            sync1_q   <= di_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
            edge_q    <= edge_d;
            ts_q      <= ts_d;
        end
    end

    assign pending_o = pending_q;
    assign edge_o    = edge_q;
    assign ts_o      = ts_q;
    assign lost_o    = lost_s;

endmodule

// File: rtl/multi_timestamp.sv
// Multi-channel edge timestamper: per-channel capture, round-robin arbiter,
// event FIFO and a three-word first-word-fall-through serializer.
module multi_timestamp
    import multi_ts_pkg::*;
#(
    parameter int         N_CH       = 4,
    parameter int         TS_WIDTH   = 64,
    parameter int         EVT_DEPTH  = 16,
    parameter logic [3:0] IDENTIFIER = 4'b0111
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    input  logic [N_CH-1:0]     DI,
    input  logic [N_CH-1:0]     EN_RISE,
    input  logic [N_CH-1:0]     EN_FALL,
    input  logic [TS_WIDTH-1:0] EXT_TIMESTAMP,
    input  logic                FIFO_READ,
    output logic                FIFO_EMPTY,
    output logic [31:0]         FIFO_DATA,
    output logic [7:0]          LOST_CNT
);

    localparam int             AW        = $clog2(EVT_DEPTH);
    localparam logic [AW:0]    CNT_FULL  = (AW+1)'(EVT_DEPTH);
    localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);

    logic [N_CH-1:0]      pending_s;
    logic [N_CH-1:0]      edge_s;
    logic [N_CH-1:0]      lost_s;
    logic [N_CH-1:0]      grant_s;
    logic [TS_WIDTH-1:0]  ts_s [N_CH];

    logic [CH_W-1:0]      ptr_q;
    logic [CH_W-1:0]      ptr_d;
    logic [CH_W-1:0]      gnt_idx_s;
    logic                 gnt_vld_s;
    int                   dist_s;
    int                   best_s;
    logic                 sel_edge_s;
    logic [TS_WIDTH-1:0]  sel_ts_s;
    logic [PAYLOAD_W-1:0] wr_payload_s;

    logic [PAYLOAD_W-1:0] mem_q [EVT_DEPTH];
    logic [AW-1:0]        wr_ptr_q;
    logic [AW-1:0]        wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q;
    logic [AW-1:0]        rd_ptr_d;
    logic [AW:0]          cnt_q;
    logic [AW:0]          cnt_d;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 pop_s;

    ser_state_e           state_q;
    ser_state_e           state_d;
    logic                 empty_q;
    logic                 empty_d;
    logic [WORD_W-1:0]    data_q;
    logic [WORD_W-1:0]    data_d;

    logic [5:0]           lost_inc_s;
    logic [8:0]           lost_sum_s;
    logic [7:0]           lost_cnt_q;
    logic [7:0]           lost_cnt_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ts_channel_capture #(
            .TS_WIDTH (TS_WIDTH)
        ) u_cap (
            .clk_i     (BUS_CLK),
            .rst_i     (BUS_RST),
            .di_i      (DI[g]),
            .en_rise_i (EN_RISE[g]),
            .en_fall_i (EN_FALL[g]),
            .ts_i      (EXT_TIMESTAMP),
            .grant_i   (grant_s[g]),
            .pending_o (pending_s[g]),
            .edge_o    (edge_s[g]),
            .ts_o      (ts_s[g]),
            .lost_o    (lost_s[g])
        );
    end

    // Round-robin pick: the pending channel at the smallest distance past the pointer wins.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = {CH_W{1'b0}};
        best_s    = N_CH;
        dist_s    = 0;
        for (int c = 0; c < N_CH; c++) begin
            dist_s = (c >= int'(ptr_q)) ? (c - int'(ptr_q)) : (c - int'(ptr_q) + N_CH);
            if (pending_s[c] && !fifo_full_s && (dist_s < best_s)) begin
                best_s    = dist_s;
                gnt_vld_s = 1'b1;
                gnt_idx_s = CH_W'(c);
            end else begin
                best_s    = best_s;
            end
        end
    end

    // Grant decode, payload mux and pointer advance.
    always_comb begin
        grant_s    = {N_CH{1'b0}};
        sel_edge_s = 1'b0;
        sel_ts_s   = {TS_WIDTH{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            if (gnt_vld_s && (gnt_idx_s == CH_W'(c))) begin
                grant_s[c] = 1'b1;
                sel_edge_s = edge_s[c];
                sel_ts_s   = ts_s[c];
            end else begin
                grant_s[c] = 1'b0;
            end
        end
        wr_payload_s = {2'b00, sel_edge_s, gnt_idx_s, sel_ts_s};
        if (gnt_vld_s) begin
            ptr_d = (gnt_idx_s == CH_W'(N_CH - 1)) ? {CH_W{1'b0}} : (gnt_idx_s + CH_W'(1));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Event FIFO bookkeeping; an event leaves only when its last word is read.
    always_comb begin
        fifo_full_s  = (cnt_q == CNT_FULL);
        fifo_empty_s = (cnt_q == {(AW+1){1'b0}});
        push_s       = gnt_vld_s;
        pop_s        = (state_q == ST_W2) && FIFO_READ;
        wr_ptr_d     = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d     = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        cnt_d        = cnt_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
    end

    // Serializer next state; output word is registered from the state being entered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = fifo_empty_s ? ST_IDLE : ST_W0;
            ST_W0:   state_d = FIFO_READ ? ST_W1 : ST_W0;
            ST_W1:   state_d = FIFO_READ ? ST_W2 : ST_W1;
            ST_W2:   state_d = FIFO_READ ? ((cnt_q > CNT_ONE) ? ST_W0 : ST_IDLE) : ST_W2;
            default: state_d = ST_IDLE;
        endcase
        empty_d = (state_d == ST_IDLE);
        if (state_d == ST_IDLE) begin
            data_d = {WORD_W{1'b0}};
        end else begin
            data_d = pack_word(IDENTIFIER, state_word_idx(state_d), mem_q[rd_ptr_d]);
        end
    end

    // Saturating drop counter; several channels may drop in the same cycle.
    always_comb begin
        lost_inc_s = 6'd0;
        for (int c = 0; c < N_CH; c++) begin
            lost_inc_s = lost_inc_s + {5'd0, lost_s[c]};
        end
        lost_sum_s = {1'b0, lost_cnt_q} + {3'd0, lost_inc_s};
        lost_cnt_d = (lost_sum_s > 9'd255) ? 8'hFF : lost_sum_s[7:0];
    end

    // Event storage; contents are don't-care outside the valid pointer window.
    always_ff @(posedge BUS_CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_payload_s;
        end
    end

    // Control state: arbiter pointer, FIFO pointers, serializer and outputs.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            ptr_q      <= {CH_W{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            cnt_q      <= {(AW+1){1'b0}};
            state_q    <= ST_IDLE;
            empty_q    <= 1'b1;
            data_q     <= {WORD_W{1'b0}};
            lost_cnt_q <= 8'd0;
        end else begin
            ptr_q      <= ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            empty_q    <= empty_d;
            data_q     <= data_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    assign FIFO_EMPTY = empty_q;
    assign FIFO_DATA  = data_q;
    assign LOST_CNT   = lost_cnt_q;

endmodule
